// File: rtl/gate_selftest_pkg.sv
// Shared types and constants for the XOR/XNOR gate self-test engine.
package gate_selftest_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int NUM_VEC = 4;

    // Gray order, entry 0 in the low bits: 00, 01, 11, 10
    localparam logic [2*NUM_VEC-1:0] VEC_SEQ = {2'b10, 2'b11, 2'b01, 2'b00};

    function automatic logic [1:0] vec_at(input logic [1:0] idx);
        return VEC_SEQ[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/gate_golden_ref.sv
// Combinational golden model of the two-input XOR/XNOR gate.
module gate_golden_ref (
    input  logic i_a,
    input  logic i_b,
    output logic o_xor,
    output logic o_xnor
);
    assign o_xor  = i_a ^ i_b;
    assign o_xnor = ~(i_a ^ i_b);
endmodule

// File: rtl/gate_selftest_checker.sv
// Self-test engine: sweeps the XOR/XNOR gate through every input vector
// and checks its outputs against the golden reference.
module gate_selftest_checker
    import gate_selftest_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    input  logic             xor_i,
    input  logic             xnor_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       fail_vec
);
    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam int PC_W = $clog2(PASSES + 1);
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [PC_W-1:0] LAST_PASS = PC_W'(PASSES - 1);

    state_t           r_state;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [1:0]       r_fail;
    logic [SC_W-1:0]  r_settle;
    logic [1:0]       r_idx;
    logic [PC_W-1:0]  r_pass_cnt;

    logic [1:0]       w_vec;
    logic             w_exp_xor;
    logic             w_exp_xnor;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;
    logic             w_last_vec;
    logic             w_last_pass;

    gate_golden_ref u_ref (
        .i_a    (r_a),
        .i_b    (r_b),
        .o_xor  (w_exp_xor),
        .o_xnor (w_exp_xnor)
    );

    assign w_vec       = vec_at(r_idx);
    assign w_mismatch  = (xor_i != w_exp_xor) || (xnor_i != w_exp_xnor);
    assign w_err_next  = (w_mismatch && r_err != '1) ? r_err + 1'b1 : r_err;
    assign w_last_vec  = (r_idx == 2'(NUM_VEC - 1));
    assign w_last_pass = (r_pass_cnt == LAST_PASS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_fail     <= 2'b00;
            r_settle   <= '0;
            r_idx      <= 2'd0;
            r_pass_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err      <= '0;
                        r_fail     <= 2'b00;
                        r_pass     <= 1'b0;
                        r_idx      <= 2'd0;
                        r_pass_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    {r_a, r_b} <= w_vec;
                    r_settle   <= SETTLE_LOAD;
                    r_state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle == '0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                S_CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch && r_err == '0) begin
                        r_fail <= {r_a, r_b};
                    end
                    r_idx <= r_idx + 2'd1;
                    if (w_last_vec) begin
                        r_pass_cnt <= r_pass_cnt + 1'b1;
                    end
                    if (w_last_vec && w_last_pass) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_APPLY;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a_o      = r_a;
    assign b_o      = r_b;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err;
    assign fail_vec = r_fail;

endmodule

// File: doc/gate_selftest_checker.md
# gate_selftest_checker

Synthesizable self-test engine for the two-input special gate (XOR/XNOR outputs). It drives the gate's `a`/`b` inputs through an exhaustive vector sweep and waits a programmable settle time. It then samples the gate's `s_xor`/`s_xnor` outputs and compares them against a golden model, reporting pass/fail, an error count and the first failing vector. It sits beside the gate inside the day's top level and replaces the simulation-only stimulus bench with on-chip checking.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: idle cycles between driving a vector and sampling outputs (≥1).
- `PASSES`, default 1: number of full 4-vector sweeps per run (≥1).
- `ERR_W`, default 8: width of the error counter.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `a_o`  out  1  drives gate input `a`.
- `b_o`  out  1  drives gate input `b`.
- `xor_i`  in  1  gate `s_xor` output.
- `xnor_i`  in  1  gate `s_xnor` output.
- `busy`  out  1  high from first APPLY through last CHECK.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  high when the last completed run had zero errors; held until the next start.
- `err_cnt`  out  ERR_W  mismatching checks in the current or last run; saturating.
- `fail_vec`  out  2  `{a,b}` of the first mismatch in the run; valid when `err_cnt != 0`.

## Operation
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE:
  - `start=1` clears `err_cnt`, `fail_vec` and `pass`.
  - Resets the vector index and pass counter.
  - Goes to APPLY.
- APPLY: drives `{a_o,b_o}` from the vector sequence 00, 01, 11, 10 (fixed Gray order), loads the settle counter with `SETTLE_CYCLES-1` and goes to SETTLE.
- SETTLE: decrements the counter; at 0 goes to CHECK. `a_o`/`b_o` are held stable.
- CHECK:
  - Expected values are `xor = a_o^b_o` and `xnor = ~(a_o^b_o)`.
  - A mismatch on either output counts as one error. `err_cnt` increments and saturates at `2^ERR_W-1`.
  - On the first error of the run, latches `{a_o,b_o}` into `fail_vec`.
  - Then advances the index. After vector 10, it increments the pass counter.
  - If more vectors or passes remain, goes to APPLY; otherwise goes to DONE.
- DONE: `done=1` and `pass=(err_cnt==0)`, using the count as updated by the final CHECK. Returns to IDLE next cycle.
- `start` outside IDLE is ignored; it is neither queued nor restarted.
- `a_o`/`b_o` hold the last vector (10) after a run until the next APPLY.

## Timing
- Reset values: state IDLE, `a_o=0`, `b_o=0`, `busy=0`, `done=0`, `pass=0`, `err_cnt=0`, `fail_vec=00`.
- Per vector: 1 APPLY + `SETTLE_CYCLES` SETTLE + 1 CHECK = `SETTLE_CYCLES+2` cycles.
- With `start` sampled at edge 0, `busy` rises after edge 0.
- `done` is high in the cycle after edge `4·PASSES·(SETTLE_CYCLES+2)`. With the defaults, that is after edge 16.
- Sampling occurs in CHECK, `SETTLE_CYCLES+1` edges after the vector is driven.
- Reset mid-run: all outputs return to reset values immediately (asynchronous). No partial result survives. The next `start` runs cleanly.
- Run back-to-back: `start` held high through DONE is sampled in the following IDLE cycle. The new run begins there, one idle cycle between runs.

## Structure
- Shared package `gate_selftest_pkg` holds:
  - the state enum;
  - the 4-entry vector-sequence constant (00, 01, 11, 10);
  - `NUM_VEC=4`.
- One sub-module, `gate_golden_ref`: combinational; takes `a`, `b` and produces the expected `xor`/`xnor`. It is reused by later gate days.
- Counters: settle (`$clog2(SETTLE_CYCLES+1)` bits), vector index (2 bits), pass counter (`$clog2(PASSES+1)` bits).

## Test plan
- Good gate, defaults, `start` pulsed → `done` after edge 16; `pass=1`; `err_cnt=0`; `a_o/b_o` sequence 00, 01, 11, 10, each held 4 cycles.
- `xor_i` stuck at 0 → `err_cnt=2` (vectors 01, 10); `fail_vec=01`; `pass=0`.
- `xor_i`/`xnor_i` swapped → `err_cnt=4`; `fail_vec=00`; `pass=0`.
- `start` re-pulsed at edge 5 of a run → ignored; `done` still after edge 16; exactly one `done` pulse.
- `rst_n` low at edge 9 → all outputs at reset values within the same cycle; a restart with a good gate gives `pass=1`.
- `ERR_W=2`, `PASSES=2`, both outputs inverted → 8 mismatches; `err_cnt` saturates at 3; `done` after edge 32.
